matrix_tile_dispatcher: RTL and testbench
=========================================

Name: matrix_tile_dispatcher

Overview:
- Parametrised successor to the single-core matrix dispatcher.
- Accepts one GEMM instruction (n, m, p, A/B/C base addresses, traversal mode) and walks the ceil(m/ROW_SIZE) x ceil(p/COLUMN_SIZE) tile grid.
- Emits one tile operation per handshake to the matrix-mul core, with edge-tile masks and first/last flags.
- Pulses done when the final tile is accepted.
- Sits between the instruction BRAM reader and matrix_mul_ctrl.

Parameters:
ROW_SIZE, 8, tile rows; power of two >= 2
COLUMN_SIZE, 8, tile columns; power of two >= 2
DIM_W, 16, width of n/m/p fields
ADDR_W, 17, width of every tile address

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_inst  in  $bits(tdisp_inst_t)  instruction: n, m, p, a_base, b_base, c_base, col_order
s_valid  in  1  instruction valid
s_ready  out  1  dispatcher idle, can accept an instruction
m_op  out  $bits(tdisp_op_t)  tile op: a_addr, b_addr, c_addr, a_line, b_line, c_line, n, rows_valid, cols_valid, first, last
m_valid  out  1  tile op valid
m_ready  in  1  core accepts op
done  out  1  one-cycle pulse: instruction complete
busy  out  1  state != IDLE

Behaviour:
- Tile counts (registered at s handshake):
  - M_T = ceil(m/ROW_SIZE), P_T = ceil(p/COLUMN_SIZE).
  - Width DIM_W-log2(ROW_SIZE)+1 (resp. COLUMN_SIZE).
  - No overflow at m = 2^DIM_W-1.
- FSM states:
  - IDLE: s_ready=1. On s_valid: latch the instruction; go to ISSUE if M_T!=0 and P_T!=0, else go to FIN.
  - ISSUE: m_valid=1. Advance to the next tile on m_valid&m_ready. On acceptance of the tile with last=1, go to FIN.
  - FIN: done=1 for exactly one cycle, then return to IDLE.
- Latency:
  - Handshake on edge k gives m_valid with tile (0,0) after edge k+1.
  - With m_ready held at 1, one tile per cycle and no bubbles.
- Handshake rules:
  - m_op and m_valid are registered.
  - m_op must stay stable while m_valid & !m_ready.
  - m_valid never drops without acceptance.
- Traversal:
  - col_order=0: j (p-tile) inner, i outer.
  - col_order=1: i inner, j outer.
- Addresses (maintained incrementally, no multipliers):
  - a_addr = a_base + i
  - b_addr = b_base + j
  - c_addr = c_base + i*(P_T*COLUMN_SIZE) + j
  - Row step uses a registered constant P_T<<log2(COLUMN_SIZE).
  - All sums are modulo 2^ADDR_W (wrap, no saturation).
- Line sizes and n:
  - a_line = M_T; b_line = c_line = P_T.
  - n is passed through unchanged; n=0 is legal and issued as-is.
- Edge masks:
  - rows_valid = ROW_SIZE, except on the last i-row: m mod ROW_SIZE when nonzero.
  - cols_valid is analogous for the last j-column.
- Flags:
  - first=1 only on tile (0,0).
  - last=1 only on tile (M_T-1, P_T-1).
- Zero dims: m=0 or p=0 issues no ops; done pulses 2 cycles after the s handshake.
- m_ready asserted while m_valid=0 is ignored.
- s_valid while busy is ignored (s_ready=0); the instruction is not consumed.
- Reset values: state=IDLE, s_ready=1, m_valid=0, done=0, busy=0, all counters and m_op=0.
- Reset mid-instruction: immediate abort, no done pulse, the instruction is lost.

Decomposition:
- Package tdisp_pkg holds:
  - tdisp_inst_t, tdisp_op_t
  - state enum tdisp_state_e
  - localparams for ceil/log2 helper widths
- One natural sub-module, tdisp_tile_counter: a nested i/j counter with wrap flags and an order-select input, reused for address stepping.

Test Plan:
- m=p=16, n=8, row order, bases 0/0x100/0x200, m_ready=1 -> 4 ops, consecutive cycles:
  - (a,b,c) = (0,0x100,0x200), (0,0x101,0x201), (1,0x100,0x210), (1,0x101,0x211)
  - last on op 4; done one cycle after.
- m=20, p=10, col_order=1 -> 6 ops in order i0j0,i1j0,i2j0,i0j1,...; rows_valid=4 on i=2, cols_valid=2 on j=1, else 8.
- Random m_ready (30% high) on m=p=24 -> 9 ops in order, m_op stable under backpressure, no duplicates, single done.
- m=0, p=64 -> no m_valid; done pulses 2 cycles after the handshake; s_ready back to 1.
- Async rst asserted mid-ISSUE (after 3 of 9 ops) -> m_valid=0 immediately, no done; next instruction restarts at tile (0,0) with first=1.
- m=p=65535 -> M_T=P_T=8192, no counter overflow; final c_addr = (c_base + 8191*65536 + 8191) mod 2^17.

Source files
------------

// File: rtl/tdisp_pkg.sv
// Shared types and widths for the matrix tile dispatcher.
//   tdisp_inst_t  : GEMM instruction (n, m, p, A/B/C base addresses, traversal order)
//   tdisp_op_t    : one tile operation handed to the matrix-mul core
//   tdisp_state_e : dispatcher FSM states
// The struct widths are fixed here; the top-level parameters default to
// these values and must be kept in step with them.
package tdisp_pkg;

   localparam int TDISP_ROW_SIZE    = 8;
   localparam int TDISP_COLUMN_SIZE = 8;
   localparam int TDISP_DIM_W       = 16;
   localparam int TDISP_ADDR_W      = 17;

   localparam int TDISP_ROW_LOG = $clog2(TDISP_ROW_SIZE);
   localparam int TDISP_COL_LOG = $clog2(TDISP_COLUMN_SIZE);

   // One extra bit so ceil(m/ROW_SIZE) cannot overflow at m = 2^DIM_W-1.
   localparam int TDISP_MT_W = TDISP_DIM_W - TDISP_ROW_LOG + 1;
   localparam int TDISP_PT_W = TDISP_DIM_W - TDISP_COL_LOG + 1;

   // Edge masks must be able to hold the full tile size itself.
   localparam int TDISP_RV_W = TDISP_ROW_LOG + 1;
   localparam int TDISP_CV_W = TDISP_COL_LOG + 1;

   typedef struct packed {
      logic [TDISP_DIM_W-1:0]  n;
      logic [TDISP_DIM_W-1:0]  m;
      logic [TDISP_DIM_W-1:0]  p;
      logic [TDISP_ADDR_W-1:0] a_base;
      logic [TDISP_ADDR_W-1:0] b_base;
      logic [TDISP_ADDR_W-1:0] c_base;
      logic                    col_order;
   } tdisp_inst_t;

   typedef struct packed {
      logic [TDISP_ADDR_W-1:0] a_addr;
      logic [TDISP_ADDR_W-1:0] b_addr;
      logic [TDISP_ADDR_W-1:0] c_addr;
      logic [TDISP_MT_W-1:0]   a_line;
      logic [TDISP_PT_W-1:0]   b_line;
      logic [TDISP_PT_W-1:0]   c_line;
      logic [TDISP_DIM_W-1:0]  n;
      logic [TDISP_RV_W-1:0]   rows_valid;
      logic [TDISP_CV_W-1:0]   cols_valid;
      logic                    first;
      logic                    last;
   } tdisp_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_FIN   = 2'd3
   } tdisp_state_e;

endpackage

// File: rtl/tdisp_tile_counter.sv
// Nested i/j tile counter.
//   clk, rst       : clock, asynchronous active-high reset
//   clr            : return both counters to zero
//   adv            : step to the next tile
//   col_order      : 0 = j inner / i outer, 1 = i inner / j outer
//   i_max, j_max   : last index of each dimension
//   i_next, j_next : indices of the tile that follows the current one
//   i_inc, i_wrap  : the step increments / wraps i (same for j); the top
//                    uses these to step its addresses without multipliers
module tdisp_tile_counter #(
   parameter int I_W = 14,
   parameter int J_W = 14
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           adv,
   input  logic           col_order,
   input  logic [I_W-1:0] i_max,
   input  logic [J_W-1:0] j_max,
   output logic [I_W-1:0] i_next,
   output logic [J_W-1:0] j_next,
   output logic           i_inc,
   output logic           i_wrap,
   output logic           j_inc,
   output logic           j_wrap
);

   localparam logic [I_W-1:0] I_ONE = 1;
   localparam logic [J_W-1:0] J_ONE = 1;

   logic [I_W-1:0] i_reg;
   logic [J_W-1:0] j_reg;

   always_comb begin
      i_inc  = 1'b0;
      i_wrap = 1'b0;
      j_inc  = 1'b0;
      j_wrap = 1'b0;
      if (!col_order) begin
         if (j_reg == j_max) begin
            j_wrap = 1'b1;
            if (i_reg == i_max) i_wrap = 1'b1;
            else                i_inc  = 1'b1;
         end else begin
            j_inc = 1'b1;
         end
      end else begin
         if (i_reg == i_max) begin
            i_wrap = 1'b1;
            if (j_reg == j_max) j_wrap = 1'b1;
            else                j_inc  = 1'b1;
         end else begin
            i_inc = 1'b1;
         end
      end
      i_next = i_wrap ? '0 : (i_inc ? i_reg + I_ONE : i_reg);
      j_next = j_wrap ? '0 : (j_inc ? j_reg + J_ONE : j_reg);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_reg <= '0;
         j_reg <= '0;
      end else if (clr) begin
         i_reg <= '0;
         j_reg <= '0;
      end else if (adv) begin
         i_reg <= i_next;
         j_reg <= j_next;
      end
   end

endmodule

// File: rtl/matrix_tile_dispatcher.sv
// Matrix tile dispatcher: takes one GEMM instruction and walks the
// ceil(m/ROW_SIZE) x ceil(p/COLUMN_SIZE) tile grid, emitting one tile
// operation per handshake to the matrix-mul core.
//   clk, rst          : clock, asynchronous active-high reset
//   s_inst, s_valid   : instruction in (tdisp_inst_t), s_ready = idle
//   m_op, m_valid     : registered tile op out (tdisp_op_t), m_ready from core
//   done              : one-cycle pulse after the last tile is accepted
//   busy              : dispatcher is not idle
// A setup state sits between the handshake and the first tile so that the
// first tile (masks, last flag) is built from the registered tile counts.
module matrix_tile_dispatcher
   import tdisp_pkg::*;
#(
   parameter int ROW_SIZE    = TDISP_ROW_SIZE,
   parameter int COLUMN_SIZE = TDISP_COLUMN_SIZE,
   parameter int DIM_W       = TDISP_DIM_W,
   parameter int ADDR_W      = TDISP_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$bits(tdisp_inst_t)-1:0] s_inst,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [$bits(tdisp_op_t)-1:0]  m_op,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          done,
   output logic                          busy
);

   localparam int ROW_LOG = $clog2(ROW_SIZE);
   localparam int COL_LOG = $clog2(COLUMN_SIZE);

   localparam logic [ADDR_W-1:0]     ADDR_ONE  = 1;
   localparam logic [TDISP_MT_W-1:0] MT_ONE    = 1;
   localparam logic [TDISP_PT_W-1:0] PT_ONE    = 1;
   localparam logic [TDISP_RV_W-1:0] ROWS_FULL = TDISP_RV_W'(ROW_SIZE);
   localparam logic [TDISP_CV_W-1:0] COLS_FULL = TDISP_CV_W'(COLUMN_SIZE);

   tdisp_inst_t  inst_in;
   tdisp_op_t    op_reg;
   tdisp_state_e state_reg, state_next;

   logic                  m_valid_reg;
   logic [TDISP_MT_W-1:0] mt_reg, mt_calc;
   logic [TDISP_PT_W-1:0] pt_reg, pt_calc;
   logic [DIM_W:0]        m_ext, p_ext;
   logic [ADDR_W-1:0]     a_base_reg, b_base_reg, c_base_reg;
   logic [ADDR_W-1:0]     c_stride_reg, c_row_reg, c_row_next;
   logic [DIM_W-1:0]      n_reg;
   logic                  col_order_reg;
   logic [ROW_LOG-1:0]    row_rem_reg;
   logic [COL_LOG-1:0]    col_rem_reg;
   logic [TDISP_RV_W-1:0] rows_edge;
   logic [TDISP_CV_W-1:0] cols_edge;

   logic                  accept, adv, cnt_clr;
   logic [TDISP_MT_W-1:0] i_max, i_next;
   logic [TDISP_PT_W-1:0] j_max, j_next;
   logic                  i_inc, i_wrap, j_inc, j_wrap;

   assign inst_in = tdisp_inst_t'(s_inst);
   assign m_op    = op_reg;
   assign m_valid = m_valid_reg;

   // Ceiling divide in DIM_W+1 bits so m = 2^DIM_W-1 does not overflow.
   assign m_ext   = {1'b0, inst_in.m} + (DIM_W+1)'(ROW_SIZE - 1);
   assign p_ext   = {1'b0, inst_in.p} + (DIM_W+1)'(COLUMN_SIZE - 1);
   assign mt_calc = TDISP_MT_W'(m_ext >> ROW_LOG);
   assign pt_calc = TDISP_PT_W'(p_ext >> COL_LOG);

   assign i_max = mt_reg - MT_ONE;
   assign j_max = pt_reg - PT_ONE;

   // Masks used on the final row / column of the grid.
   assign rows_edge = (row_rem_reg != '0) ? TDISP_RV_W'(row_rem_reg) : ROWS_FULL;
   assign cols_edge = (col_rem_reg != '0) ? TDISP_CV_W'(col_rem_reg) : COLS_FULL;

   assign accept  = m_valid_reg & m_ready;
   // The last tile is not stepped past; the FSM leaves ISSUE instead.
   assign adv     = accept & ~op_reg.last;
   assign cnt_clr = (state_reg == ST_LOAD);

   tdisp_tile_counter #(
      .I_W (TDISP_MT_W),
      .J_W (TDISP_PT_W)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .adv       (adv),
      .col_order (col_order_reg),
      .i_max     (i_max),
      .j_max     (j_max),
      .i_next    (i_next),
      .j_next    (j_next),
      .i_inc     (i_inc),
      .i_wrap    (i_wrap),
      .j_inc     (j_inc),
      .j_wrap    (j_wrap)
   );

   // Base of the C row for the next tile: c_base + i*(P_T*COLUMN_SIZE).
   assign c_row_next = i_wrap ? c_base_reg :
                       (i_inc ? c_row_reg + c_stride_reg : c_row_reg);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // FSM next state and status outputs
   always_comb begin
      state_next = state_reg;
      s_ready    = 1'b0;
      done       = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (s_valid) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            state_next = ((mt_reg != '0) && (pt_reg != '0)) ? ST_ISSUE : ST_FIN;
         end
         ST_ISSUE: begin
            if (accept && op_reg.last) state_next = ST_FIN;
         end
         ST_FIN: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Instruction latch, tile op register and address stepping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_reg   <= 1'b0;
         op_reg        <= '0;
         mt_reg        <= '0;
         pt_reg        <= '0;
         a_base_reg    <= '0;
         b_base_reg    <= '0;
         c_base_reg    <= '0;
         c_stride_reg  <= '0;
         c_row_reg     <= '0;
         n_reg         <= '0;
         col_order_reg <= 1'b0;
         row_rem_reg   <= '0;
         col_rem_reg   <= '0;
      end else begin
         m_valid_reg <= (state_next == ST_ISSUE);

         if (state_reg == ST_IDLE && s_valid) begin
            mt_reg        <= mt_calc;
            pt_reg        <= pt_calc;
            a_base_reg    <= inst_in.a_base;
            b_base_reg    <= inst_in.b_base;
            c_base_reg    <= inst_in.c_base;
            c_stride_reg  <= ADDR_W'(pt_calc) << COL_LOG;
            n_reg         <= inst_in.n;
            col_order_reg <= inst_in.col_order;
            row_rem_reg   <= inst_in.m[ROW_LOG-1:0];
            col_rem_reg   <= inst_in.p[COL_LOG-1:0];
         end

         if (state_reg == ST_LOAD) begin
            op_reg.a_addr     <= a_base_reg;
            op_reg.b_addr     <= b_base_reg;
            op_reg.c_addr     <= c_base_reg;
            op_reg.a_line     <= mt_reg;
            op_reg.b_line     <= pt_reg;
            op_reg.c_line     <= pt_reg;
            op_reg.n          <= n_reg;
            op_reg.rows_valid <= (mt_reg == MT_ONE) ? rows_edge : ROWS_FULL;
            op_reg.cols_valid <= (pt_reg == PT_ONE) ? cols_edge : COLS_FULL;
            op_reg.first      <= 1'b1;
            op_reg.last       <= (mt_reg == MT_ONE) && (pt_reg == PT_ONE);
            c_row_reg         <= c_base_reg;
         end else if (adv) begin
            op_reg.a_addr     <= i_wrap ? a_base_reg :
                                 (i_inc ? op_reg.a_addr + ADDR_ONE : op_reg.a_addr);
            op_reg.b_addr     <= j_wrap ? b_base_reg :
                                 (j_inc ? op_reg.b_addr + ADDR_ONE : op_reg.b_addr);
            op_reg.c_addr     <= c_row_next + ADDR_W'(j_next);
            op_reg.rows_valid <= (i_next == i_max) ? rows_edge : ROWS_FULL;
            op_reg.cols_valid <= (j_next == j_max) ? cols_edge : COLS_FULL;
            op_reg.first      <= 1'b0;
            op_reg.last       <= (i_next == i_max) && (j_next == j_max);
            c_row_reg         <= c_row_next;
         end
      end
   end

endmodule

// File: tb/tb_matrix_tile_dispatcher.sv
// Self-checking bench for matrix_tile_dispatcher: a reference model fills a
// scoreboard with the expected tile ops when an instruction is sent, and a
// monitor pops and compares every accepted op.
module tb_matrix_tile_dispatcher;
   import tdisp_pkg::*;

   localparam int RS = TDISP_ROW_SIZE;
   localparam int CS = TDISP_COLUMN_SIZE;

   logic                           clk = 1'b0;
   logic                           rst = 1'b1;
   logic [$bits(tdisp_inst_t)-1:0] s_inst = '0;
   logic                           s_valid = 1'b0;
   logic                           s_ready;
   logic [$bits(tdisp_op_t)-1:0]   m_op;
   logic                           m_valid;
   logic                           m_ready = 1'b1;
   logic                           done;
   logic                           busy;

   matrix_tile_dispatcher dut (
      .clk     (clk),
      .rst     (rst),
      .s_inst  (s_inst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .m_op    (m_op),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .done    (done),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int        n_checks = 0;
   int        n_pass   = 0;
   tdisp_op_t sb[$];
   int        cyc = 0;
   int        ready_mode = 0;        // 0: always ready, 1: ~30% ready
   bit        stop_when_empty = 1'b0;
   int        exp_done_cyc = -1;
   int        exp_first_cyc = -1;
   int        n_done = 0;
   int        n_acc = 0;
   bit        prev_stall = 1'b0;
   bit        prev_acc_nonlast = 1'b0;
   tdisp_op_t prev_op;
   tdisp_op_t got_op, exp_op;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: enumerate the tile grid directly with multiplies.
   task automatic push_tiles(input tdisp_inst_t in, input int limit);
      int mt, pt, i, j, cnt;
      tdisp_op_t op;
      mt  = (int'(in.m) + RS - 1) / RS;
      pt  = (int'(in.p) + CS - 1) / CS;
      cnt = 0;
      for (int k = 0; k < mt * pt && cnt < limit; k++) begin
         if (!in.col_order) begin i = k / pt; j = k % pt; end
         else               begin j = k / mt; i = k % mt; end
         op.a_addr     = TDISP_ADDR_W'(int'(in.a_base) + i);
         op.b_addr     = TDISP_ADDR_W'(int'(in.b_base) + j);
         op.c_addr     = TDISP_ADDR_W'(int'(in.c_base) + i * pt * CS + j);
         op.a_line     = TDISP_MT_W'(mt);
         op.b_line     = TDISP_PT_W'(pt);
         op.c_line     = TDISP_PT_W'(pt);
         op.n          = in.n;
         op.rows_valid = TDISP_RV_W'((i == mt - 1 && int'(in.m) % RS != 0) ? int'(in.m) % RS : RS);
         op.cols_valid = TDISP_CV_W'((j == pt - 1 && int'(in.p) % CS != 0) ? int'(in.p) % CS : CS);
         op.first      = (k == 0);
         op.last       = (k == mt * pt - 1);
         sb.push_back(op);
         cnt++;
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (stop_when_empty && sb.size() == 0) m_ready = 1'b0;
      else if (ready_mode == 1)              m_ready = ($urandom_range(0, 99) < 30);
      else                                   m_ready = 1'b1;
   end

   // Monitor: sampled on the falling edge, one line per failing op.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall       = 1'b0;
         prev_acc_nonlast = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", m_valid, 1);
            check("hold_op", m_op, prev_op);
         end
         if (prev_acc_nonlast && ready_mode == 0) check("no_bubble", m_valid, 1);
         prev_acc_nonlast = 1'b0;
         if (done) begin
            check("done_time", cyc, exp_done_cyc);
            exp_done_cyc = -1;
            n_done++;
         end
         if (m_valid && m_ready) begin
            got_op = tdisp_op_t'(m_op);
            if (sb.size() == 0) begin
               check("op_unexpected", m_valid, 0);
            end else begin
               exp_op = sb.pop_front();
               check("op", got_op, exp_op);
               if (got_op.first && ready_mode == 0) check("first_latency", cyc, exp_first_cyc);
               if (got_op.last) exp_done_cyc = cyc + 1;
               else             prev_acc_nonlast = 1'b1;
            end
            n_acc++;
         end
         prev_stall = m_valid && !m_ready;
         prev_op    = tdisp_op_t'(m_op);
      end
   end

   task automatic send(input tdisp_inst_t in, input int limit);
      int g = 0;
      @(posedge clk); #1;
      while (!s_ready && g < 100) begin @(posedge clk); #1; g++; end
      push_tiles(in, limit);
      s_inst  = in;
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      exp_first_cyc = cyc + 1;
      if (in.m == 0 || in.p == 0) exp_done_cyc = cyc + 1;
   endtask

   task automatic wait_done(input int start, input int budget);
      int t = 0;
      while (n_done == start && t < budget) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      check("done_count", n_done - start, 1);
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic wait_sb_empty(input int budget);
      int t = 0;
      while (sb.size() != 0 && t < budget) begin @(negedge clk); t++; end
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_done", done, 0);
      check("rst_s_ready", s_ready, 1);
      sb.delete();
      exp_done_cyc = -1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
   endtask

   function automatic tdisp_inst_t mk(input int n, input int m, input int p, input int a,
                                      input int b, input int c, input bit co);
      tdisp_inst_t r;
      r.n = TDISP_DIM_W'(n); r.m = TDISP_DIM_W'(m); r.p = TDISP_DIM_W'(p);
      r.a_base = TDISP_ADDR_W'(a); r.b_base = TDISP_ADDR_W'(b); r.c_base = TDISP_ADDR_W'(c);
      r.col_order = co;
      return r;
   endfunction

   initial begin
      int start;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_s_ready", s_ready, 1);
      check("reset_m_valid", m_valid, 0);
      check("reset_done", done, 0);
      check("reset_busy", busy, 0);
      check("reset_m_op", m_op, 0);
      #3 rst = 1'b0;

      // 2x2 grid, row order, back-to-back tiles
      start = n_done;
      send(mk(8, 16, 16, 0, 'h100, 'h200, 1'b0), 1000);
      wait_done(start, 100);

      // 3x2 grid, column order, edge masks, n = 0, C address wrap
      start = n_done;
      send(mk(0, 20, 10, 'h10, 'h20, 'h1FFF8, 1'b1), 1000);
      wait_done(start, 100);

      // Backpressure; s_valid while busy must be ignored
      ready_mode = 1;
      start = n_done;
      send(mk(5, 24, 24, 'h40, 'h80, 'h300, 1'b0), 1000);
      for (int k = 0; k < 5; k++) begin
         s_inst  = mk(1, 8, 8, 'h1234, 'h1234, 'h1234, 1'b0);
         s_valid = 1'b1;
         check("busy_s_ready", s_ready, 0);
         check("busy_flag", busy, 1);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      wait_done(start, 600);
      ready_mode = 0;

      // Zero dimensions: no ops, done two cycles after the handshake
      start = n_done;
      send(mk(3, 0, 64, 1, 2, 3, 1'b0), 1000);
      wait_done(start, 20);
      check("zero_s_ready", s_ready, 1);
      start = n_done;
      send(mk(3, 5, 0, 1, 2, 3, 1'b1), 1000);
      wait_done(start, 20);

      // Reset after three accepted tiles, then restart cleanly
      start = n_acc;
      send(mk(2, 24, 24, 'h11, 'h22, 'h33, 1'b0), 1000);
      begin
         int t = 0;
         while (n_acc < start + 3 && t < 50) begin @(negedge clk); t++; end
      end
      check("abort_progress", n_acc - start, 3);
      pulse_reset();
      start = n_done;
      repeat (4) @(negedge clk);
      check("abort_no_done", n_done - start, 0);
      send(mk(8, 16, 16, 'h1000, 'h2000, 'h3000, 1'b0), 1000);
      wait_done(start, 100);

      // Largest dimensions: 8192 x 8192 grid, check the first rows/columns
      stop_when_empty = 1'b1;
      send(mk(7, 65535, 65535, 'h1FF00, 'h10, 'h1FFF0, 1'b0), 8193);
      wait_sb_empty(9000);
      repeat (3) @(negedge clk);
      check("big_hold_valid", m_valid, 1);
      pulse_reset();
      send(mk(7, 65535, 65535, 'h5, 'h6, 'h1FFF0, 1'b1), 8192);
      wait_sb_empty(9000);
      pulse_reset();
      stop_when_empty = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
